// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control path: opcodes, sequencer states, defaults.
package mu0_pkg;

   localparam int CNT_W_DEF = 16;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JMI = 4'h5;
   localparam logic [3:0] OP_JEQ = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;
   localparam logic [3:0] OP_LDI = 4'h8;
   localparam logic [3:0] OP_LSL = 4'h9;
   localparam logic [3:0] OP_LSR = 4'hA;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC1,
      S_EXEC2,
      S_WRITE,
      S_HALT
   } seq_state_t;

endpackage

// File: rtl/mu0_op_decode.sv
// Opcode classification on ir[15:12]; also used by the ALU to spot MU0-format ops.
module mu0_op_decode
   import mu0_pkg::*;
(
   input  logic [3:0] op,
   output logic       two_phase,
   output logic       is_store,
   output logic       is_stop,
   output logic       is_mu0
);

   // Codes B-F are ARM-format ALU ops, everything at or below LSR is MU0.
   assign is_mu0    = (op <= OP_LSR);
   assign two_phase = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
   assign is_store  = (op == OP_STA);
   assign is_stop   = (op == OP_STP);

endmodule

// File: rtl/mu0_sequencer.sv
// MU0 instruction sequencer: fetch / exec1 / exec2 / write with memory req-ack,
// per-instruction skip (squash) latch, sticky halt and a saturating retire counter.
module mu0_sequencer
   import mu0_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             run,
   input  logic [15:0]      ir,
   input  logic             skipstatus,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_en,
   output logic             pc_en,
   output logic             exec1,
   output logic             exec2,
   output logic             squash,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   seq_state_t       state, state_nx, boundary_nx;
   logic             squash_q, halted_q;
   logic [CNT_W-1:0] cnt_q;
   logic             two_phase, is_store, is_stop, is_mu0;
   logic             fetch_entry;
   logic             ir_unused;

   // Only the opcode field matters to sequencing.
   assign ir_unused = ^ir[11:0];

   mu0_op_decode u_dec (
      .op        (ir[15:12]),
      .two_phase (two_phase),
      .is_store  (is_store),
      .is_stop   (is_stop),
      .is_mu0    (is_mu0)
   );

   // Where an instruction goes once it is finished: next fetch or park in IDLE.
   assign boundary_nx = run ? S_FETCH : S_IDLE;
   assign fetch_entry = (state_nx == S_FETCH) && (state != S_FETCH);

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Next state and Moore outputs; ir_en/pc_en/exec2 are qualified by mem_ack.
   always_comb begin
      state_nx = state;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      ir_en    = 1'b0;
      pc_en    = 1'b0;
      exec1    = 1'b0;
      exec2    = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) state_nx = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_en    = 1'b1;
               pc_en    = 1'b1;
               state_nx = S_EXEC1;
            end
         end
         S_EXEC1: begin
            exec1 = 1'b1;
            // A squashed LDA/ADD/SUB still takes EXEC2 so the ALU can clear SKIP.
            if (!is_mu0)                     state_nx = boundary_nx;
            else if (two_phase)              state_nx = S_EXEC2;
            else if (is_store && !squash_q)  state_nx = S_WRITE;
            else if (is_stop && !squash_q)   state_nx = S_HALT;
            else                             state_nx = boundary_nx;
         end
         S_EXEC2: begin
            mem_req = !squash_q;
            exec2   = squash_q || mem_ack;
            if (squash_q || mem_ack) state_nx = boundary_nx;
         end
         S_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) state_nx = boundary_nx;
         end
         S_HALT: begin
            state_nx = S_HALT;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Squash latches SKIP at fetch completion and is clear outside an instruction.
   always_ff @(posedge clk) begin
      if (!resetn || fetch_entry || state_nx == S_IDLE) squash_q <= 1'b0;
      else if (state == S_FETCH && mem_ack)             squash_q <= skipstatus;
   end

   // Sticky halt, set as an unsquashed STP leaves EXEC1.
   always_ff @(posedge clk) begin
      if (!resetn)                                                   halted_q <= 1'b0;
      else if (state == S_EXEC1 && is_mu0 && is_stop && !squash_q)   halted_q <= 1'b1;
   end

   // Retired-instruction counter, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (!resetn)
         cnt_q <= '0;
      else if (state == S_EXEC1 && !squash_q && cnt_q != '1)
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign squash      = squash_q;
   assign halted      = halted_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_mu0_sequencer.sv
// Bench: instruction-level model expands each instruction into per-cycle
// {inputs, expected outputs} records, which are then applied and compared.
module tb_mu0_sequencer;

   localparam int CW = 4;
   localparam logic [7:0] E_REQ = 8'h80, E_WE = 8'h40, E_IR = 8'h20, E_PC = 8'h10;
   localparam logic [7:0] E_X1  = 8'h08, E_X2 = 8'h04, E_SQ = 8'h02, E_HLT = 8'h01;

   logic          clk = 1'b0;
   logic          resetn, run, skipstatus, mem_ack;
   logic [15:0]   ir;
   logic          mem_req, mem_we, ir_en, pc_en, exec1, exec2, squash, halted;
   logic [CW-1:0] instr_count;

   mu0_sequencer #(.CNT_W(CW)) dut (
      .clk(clk), .resetn(resetn), .run(run), .ir(ir), .skipstatus(skipstatus),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_en(ir_en),
      .pc_en(pc_en), .exec1(exec1), .exec2(exec2), .squash(squash),
      .halted(halted), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst_n, run, skip, ack;
      logic [15:0]   ir;
      bit            chk;
      logic [7:0]    exp;
      logic [CW-1:0] cnt;
      string         tag;
   } vec_t;

   typedef struct {
      logic [15:0] ir;
      bit          s;
      int          wf, wm;
      bit          ra;
      string       tag;
   } dir_t;

   vec_t  q[$];
   dir_t  tbl[8];
   int    m_cnt;
   bit    m_idle, m_halt;
   string m_tag;
   int    n_vec, n_bad;
   int    w;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic rn, input logic r, input logic s, input logic a,
                       input logic [15:0] i, input bit c, input logic [7:0] e);
      vec_t v;
      v.rst_n = rn; v.run = r; v.skip = s; v.ack = a; v.ir = i;
      v.chk = c; v.exp = e; v.cnt = m_cnt[CW-1:0]; v.tag = m_tag;
      q.push_back(v);
   endtask

   // One instruction, starting from IDLE or FETCH; wf/wm = memory wait cycles.
   task automatic issue(input logic [15:0] i, input bit s, input int wf, input int wm,
                        input bit ra);
      logic [3:0] op;
      bit         two, st, stp, last;
      logic [7:0] sq;
      op   = i[15:12];
      two  = (op == 4'h0) || (op == 4'h2) || (op == 4'h3);
      st   = (op == 4'h1);
      stp  = (op == 4'h7);
      sq   = s ? E_SQ : 8'h00;
      last = !(two || (st && !s) || (stp && !s));
      if (m_idle) push(1, 1, rb(), rb(), i, 1, 8'h00);
      for (int k = 0; k < wf; k++) push(1, rb(), rb(), 0, i, 1, E_REQ);
      push(1, rb(), s, 1, i, 1, E_REQ | E_IR | E_PC);
      push(1, last ? ra : rb(), rb(), rb(), i, 1, E_X1 | sq);
      if (!s && m_cnt < (1 << CW) - 1) m_cnt++;
      if (two) begin
         if (s) push(1, ra, rb(), rb(), i, 1, E_X2 | E_SQ);
         else begin
            for (int k = 0; k < wm; k++) push(1, rb(), rb(), 0, i, 1, E_REQ);
            push(1, ra, rb(), 1, i, 1, E_REQ | E_X2);
         end
      end else if (st && !s) begin
         for (int k = 0; k < wm; k++) push(1, rb(), rb(), 0, i, 1, E_REQ | E_WE);
         push(1, ra, rb(), 1, i, 1, E_REQ | E_WE);
      end
      if (stp && !s) begin
         m_halt = 1; m_idle = 0;
      end else m_idle = !ra;
   endtask

   task automatic halt_cycles(input int n);
      for (int k = 0; k < n; k++) push(1, rb(), rb(), rb(), 16'($urandom), 1, E_HLT);
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) push(1, 0, rb(), rb(), 16'($urandom), 1, 8'h00);
   endtask

   task automatic reset_seq();
      push(0, rb(), rb(), rb(), 16'h0000, 0, 8'h00);
      m_cnt = 0; m_halt = 0; m_idle = 1;
   endtask

   initial begin
      resetn = 1'b0; run = 1'b0; skipstatus = 1'b0; mem_ack = 1'b0; ir = 16'h0;
      n_vec = 0; n_bad = 0; m_cnt = 0; m_idle = 1; m_halt = 0;

      tbl[0] = '{16'h2005, 1'b0, 0, 0, 1'b1, "add"};
      tbl[1] = '{16'hC101, 1'b0, 0, 0, 1'b1, "arm"};
      tbl[2] = '{16'h1010, 1'b0, 0, 3, 1'b1, "sta_wait"};
      tbl[3] = '{16'h0003, 1'b1, 0, 0, 1'b1, "lda_squash"};
      tbl[4] = '{16'h3004, 1'b0, 1, 2, 1'b0, "sub_runoff"};
      tbl[5] = '{16'h4020, 1'b0, 0, 0, 1'b1, "jmp_restart"};
      tbl[6] = '{16'h1111, 1'b1, 2, 0, 1'b1, "sta_squash"};
      tbl[7] = '{16'h7000, 1'b1, 0, 0, 1'b0, "stp_squash"};

      m_tag = "reset";
      reset_seq();
      idle_cycles(2);
      foreach (tbl[k]) begin
         m_tag = tbl[k].tag;
         issue(tbl[k].ir, tbl[k].s, tbl[k].wf, tbl[k].wm, tbl[k].ra);
      end

      // STP halts; run toggling must not restart; reset clears halt and count.
      m_tag = "stp_halt";
      issue(16'h7000, 0, 0, 0, 1);
      halt_cycles(5);
      reset_seq();
      idle_cycles(2);

      // Reset while a fetch is outstanding: request drops, nothing completes.
      m_tag = "rst_fetch";
      issue(16'hB000, 0, 0, 0, 1);
      push(1, rb(), rb(), 0, 16'h2222, 1, E_REQ);
      push(0, rb(), rb(), 0, 16'h2222, 1, E_REQ);
      m_cnt = 0; m_idle = 1;
      idle_cycles(2);

      // Counter saturation at all-ones.
      m_tag = "saturate";
      for (int k = 0; k < 18; k++) issue(16'hD000 | 16'(k), 0, 0, 0, 1);
      m_tag = "rand";
      for (int n = 0; n < 400; n++) begin
         if (m_halt) begin
            halt_cycles($urandom_range(1, 3));
            reset_seq();
         end
         if (m_idle && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
         issue(16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3) != 0);
      end

      foreach (q[k]) begin
         @(negedge clk);
         resetn = q[k].rst_n; run = q[k].run; skipstatus = q[k].skip;
         mem_ack = q[k].ack; ir = q[k].ir;
         #1;
         if (q[k].chk) begin
            n_vec++;
            if ({mem_req, mem_we, ir_en, pc_en, exec1, exec2, squash, halted} !== q[k].exp
                || instr_count !== q[k].cnt) begin
               n_bad++;
               $display("FAIL %s vec %0d: got req/we/ir/pc/x1/x2/sq/hlt=%b cnt=%0d, want %b cnt=%0d",
                        q[k].tag, k,
                        {mem_req, mem_we, ir_en, pc_en, exec1, exec2, squash, halted},
                        instr_count, q[k].exp, q[k].cnt);
            end
         end
      end

      @(negedge clk);
      resetn = 1'b0; run = 1'b0; skipstatus = 1'b0; mem_ack = 1'b0; ir = 16'h0;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_vec++;
      if ({mem_req, mem_we, ir_en, pc_en, exec1, exec2, squash, halted} !== 8'h00
          || instr_count !== '0) begin
         n_bad++;
         $display("FAIL post_reset: got req/we/ir/pc/x1/x2/sq/hlt=%b cnt=%0d, want 0 cnt=0",
                  {mem_req, mem_we, ir_en, pc_en, exec1, exec2, squash, halted}, instr_count);
      end

      @(negedge clk);
      resetn = 1'b1; run = 1'b1;
      #1;
      w = 0;
      while (mem_req !== 1'b1 && w < 8) begin
         @(negedge clk);
         #1;
         w++;
      end
      n_vec++;
      if (mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL fetch_wait: mem_req not raised within %0d cycles of run", w);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
